// File: rtl/write_back_unit.sv
// rtl/write_back_unit.sv - write-back stage: result select, load extension, late queue and register-file port arbitration
//
// Optional feature macro: WB_LATE_BYPASS_EN
//   defined   : a late result offered while the queue is empty and no pipe write is requested
//               is written straight to the output register at the next edge.
//   undefined : every late result passes through the late queue.
//
// Ports
//   i_clk, i_arstn                  clock (rising edge), asynchronous active-low reset
//   i_valid, i_reg_we, i_rd_addr    pipeline channel: retiring instruction, write enable, destination
//   i_src_data, i_result_src        packed result sources (0 ALU, 1 load, 2 PC+4, 3 PC target, 4 imm) and select
//   i_load_funct3, i_load_offset    load type and byte offset for source 1
//   o_pipe_stall                    pipeline channel not accepted this cycle
//   i_late_valid, o_late_ready      late channel handshake
//   i_late_data, i_late_rd_addr     late result and destination
//   o_late_pending                  late queue non-empty
//   o_result, o_rd_addr, o_reg_we   registered register-file write port
module write_back_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 5,
    parameter int LQ_DEPTH   = 4
) (
    input  logic                            i_clk,
    input  logic                            i_arstn,
    input  logic                            i_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   i_src_data,
    input  logic [$clog2(NUM_SRC)-1:0]      i_result_src,
    input  logic [2:0]                      i_load_funct3,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] i_load_offset,
    input  logic [REG_ADDR_W-1:0]           i_rd_addr,
    input  logic                            i_reg_we,
    output logic                            o_pipe_stall,
    input  logic                            i_late_valid,
    output logic                            o_late_ready,
    input  logic [DATA_WIDTH-1:0]           i_late_data,
    input  logic [REG_ADDR_W-1:0]           i_late_rd_addr,
    output logic                            o_late_pending,
    output logic [DATA_WIDTH-1:0]           o_result,
    output logic [REG_ADDR_W-1:0]           o_rd_addr,
    output logic                            o_reg_we
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(LQ_DEPTH);
    localparam int CNT_W  = $clog2(LQ_DEPTH + 1);

    logic [DATA_WIDTH-1:0] lq_data [LQ_DEPTH];
    logic [REG_ADDR_W-1:0] lq_addr [LQ_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  full;
    logic                  pipe_req;
    logic                  late_take;
    logic                  enq;
    logic                  deq;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [REG_ADDR_W-1:0] wr_addr;

    // Keep the low `bits` bits, fill the rest with zero or the sign bit.
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                     input int bits, input logic sgn);
        logic [DATA_WIDTH-1:0] r;
        r = v;
        if (bits < DATA_WIDTH) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (i >= bits) r[i] = sgn & v[bits-1];
            end
        end
        return r;
    endfunction

    assign full           = (count == CNT_W'(LQ_DEPTH));
    assign o_pipe_stall   = full;
    assign o_late_ready   = i_arstn & ~full;
    assign o_late_pending = (count != '0);
    assign pipe_req       = i_valid & i_reg_we & (i_rd_addr != '0) & ~full;
    // rd=0 late results complete the handshake but are discarded.
    assign late_take      = i_late_valid & o_late_ready & (i_late_rd_addr != '0);

`ifdef WB_LATE_BYPASS_EN
    assign bypass = late_take & (count == '0) & ~pipe_req;
`else
    assign bypass = 1'b0;
`endif
    assign enq = late_take & ~bypass;

    // Rotate the load word so the addressed byte lands in lane 0; bytes past the top wrap around.
    always_comb begin
        lane = '0;
        for (int b = 0; b < NBYTES; b++) begin
            lane[b*8 +: 8] = i_src_data[DATA_WIDTH + ((b + int'(i_load_offset)) % NBYTES)*8 +: 8];
        end
    end

    always_comb begin
        case (i_load_funct3)
            3'b000:  load_data = extend(lane, 8, 1'b1);
            3'b001:  load_data = extend(lane, 16, 1'b1);
            3'b010:  load_data = extend(lane, 32, 1'b1);
            3'b100:  load_data = extend(lane, 8, 1'b0);
            3'b101:  load_data = extend(lane, 16, 1'b0);
            3'b110:  load_data = extend(lane, 32, 1'b0);
            default: load_data = lane;
        endcase
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(i_result_src) == k) begin
                sel_data = (k == 1) ? load_data : i_src_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A full queue outranks the pipeline so it can always drain.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        wr_addr = '0;
        deq     = 1'b0;
        if (full) begin
            wr_en   = 1'b1;
            wr_data = lq_data[head];
            wr_addr = lq_addr[head];
            deq     = 1'b1;
        end else if (pipe_req) begin
            wr_en   = 1'b1;
            wr_data = sel_data;
            wr_addr = i_rd_addr;
        end else if (count != '0) begin
            wr_en   = 1'b1;
            wr_data = lq_data[head];
            wr_addr = lq_addr[head];
            deq     = 1'b1;
        end else if (bypass) begin
            wr_en   = 1'b1;
            wr_data = i_late_data;
            wr_addr = i_late_rd_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the pointers and count decide what is live.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            lq_data[tail] <= i_late_data;
            lq_addr[tail] <= i_late_rd_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            o_result  <= '0;
            o_rd_addr <= '0;
            o_reg_we  <= 1'b0;
        end else begin
            o_reg_we <= wr_en;
            if (wr_en) begin
                o_result  <= wr_data;
                o_rd_addr <= wr_addr;
            end
        end
    end

endmodule
